// File: rtl/fm_interval_update_pkg.sv
// Shared encodings for the FM-index interval update unit:
// base codes, count-lane layout, null address and FSM states.
package fm_interval_update_pkg;

  localparam logic [1:0] BASE_A = 2'd0;
  localparam logic [1:0] BASE_C = 2'd1;
  localparam logic [1:0] BASE_G = 2'd2;
  localparam logic [1:0] BASE_T = 2'd3;

  localparam int LANE_A = 0;
  localparam int LANE_C = 1;
  localparam int LANE_G = 2;
  localparam int LANE_T = 3;

  localparam logic [7:0] ADDR_NULL = 8'hff;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD_K,
    S_RD_L,
    S_DONE
  } state_t;

  function automatic int lane_lsb(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/fm_interval_update_occ_lane_sel.sv
// 4:1 count-lane select, shared by the Occ ROM data
// and the C table.
module occ_lane_sel
  import fm_interval_update_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic [4*CNT_W-1:0] data,
  input  logic [1:0]         sel,
  output logic [CNT_W-1:0]   lane
);

  always_comb begin
    lane = '0;
    unique case (sel)
      BASE_A: lane = data[lane_lsb(LANE_A, CNT_W) +: CNT_W];
      BASE_C: lane = data[lane_lsb(LANE_C, CNT_W) +: CNT_W];
      BASE_G: lane = data[lane_lsb(LANE_G, CNT_W) +: CNT_W];
      BASE_T: lane = data[lane_lsb(LANE_T, CNT_W) +: CNT_W];
      default: lane = '0;
    endcase
  end

endmodule

// File: rtl/fm_interval_update.sv
// FM-index backward-search step: reads Occ(k-1) and Occ(l)
// for one base and forms the narrowed SA interval.
module fm_interval_update
  import fm_interval_update_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ADDR_W-1:0]    in_k,
  input  logic [ADDR_W-1:0]    in_l,
  input  logic [1:0]           in_base,
  input  logic [4*CNT_W-1:0]   c_tbl,
  output logic                 occ_ce,
  output logic [ADDR_W-1:0]    occ_addr,
  input  logic [4*CNT_W-1:0]   occ_data,
  input  logic                 occ_valid,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDR_W-1:0]    out_k,
  output logic [ADDR_W-1:0]    out_l,
  output logic                 out_empty,
  output logic                 out_ovf
);

  state_t            state;
  logic [ADDR_W-1:0] k_q;
  logic [ADDR_W-1:0] l_q;
  logic [1:0]        base_q;
  logic [CNT_W-1:0]  occ_k;
  logic [CNT_W-1:0]  occ_lane;
  logic [CNT_W-1:0]  c_lane;
  logic [CNT_W:0]    sk;
  logic [CNT_W:0]    sl;

  occ_lane_sel #(.CNT_W(CNT_W)) u_occ_sel (
    .data (occ_data),
    .sel  (base_q),
    .lane (occ_lane)
  );

  occ_lane_sel #(.CNT_W(CNT_W)) u_c_sel (
    .data (c_tbl),
    .sel  (base_q),
    .lane (c_lane)
  );

  // One extra bit keeps the carry for the overflow and empty tests
  assign sk = {1'b0, c_lane} + {1'b0, occ_k} + {{CNT_W{1'b0}}, 1'b1};
  assign sl = {1'b0, c_lane} + {1'b0, occ_lane};

  assign in_ready = (state == S_IDLE) && !rst;

  // k=0 wraps to the all-ones address, which the ROM reads as zero
  always_comb begin
    occ_ce   = 1'b0;
    occ_addr = '0;
    unique case (state)
      S_RD_K: begin
        occ_ce   = 1'b1;
        occ_addr = k_q - {{(ADDR_W-1){1'b0}}, 1'b1};
      end
      S_RD_L: begin
        occ_ce   = 1'b1;
        occ_addr = l_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      k_q       <= '0;
      l_q       <= '0;
      base_q    <= '0;
      occ_k     <= '0;
      out_valid <= 1'b0;
      out_k     <= '0;
      out_l     <= '0;
      out_empty <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (in_valid) begin
          k_q    <= in_k;
          l_q    <= in_l;
          base_q <= in_base;
          state  <= S_RD_K;
        end
        S_RD_K: if (occ_valid) begin
          occ_k <= occ_lane;
          state <= S_RD_L;
        end
        S_RD_L: if (occ_valid) begin
          out_k     <= ADDR_W'(sk[CNT_W-1:0]);
          out_l     <= ADDR_W'(sl[CNT_W-1:0]);
          out_ovf   <= sk[CNT_W] | sl[CNT_W];
          out_empty <= sk > sl;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fm_interval_update.sv
// Bench for fm_interval_update: ROM model, expected-result
// queue with a separate output monitor, directed vectors.
module tb_fm_interval_update;
  import fm_interval_update_pkg::*;

  typedef struct {
    logic [7:0] k;
    logic [7:0] l;
    logic       e;
    logic       o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_k = '0;
  logic [7:0]  in_l = '0;
  logic [1:0]  in_base = '0;
  logic [31:0] c_tbl = 32'h0C080401;
  logic        occ_ce;
  logic [7:0]  occ_addr;
  logic [31:0] occ_data;
  logic        occ_valid;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_k;
  logic [7:0]  out_l;
  logic        out_empty;
  logic        out_ovf;

  logic [31:0] mem [256];
  int          stall_cnt = 0;
  logic        stall_now = 1'b0;
  logic [7:0]  addr_log [$];
  exp_t        sb [$];
  int          tests = 0;
  int          fails = 0;
  int          lat;

  fm_interval_update dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_k      (in_k),
    .in_l      (in_l),
    .in_base   (in_base),
    .c_tbl     (c_tbl),
    .occ_ce    (occ_ce),
    .occ_addr  (occ_addr),
    .occ_data  (occ_data),
    .occ_valid (occ_valid),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_k     (out_k),
    .out_l     (out_l),
    .out_empty (out_empty),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  assign occ_data  = (occ_addr == ADDR_NULL) ? 32'h0 : mem[occ_addr];
  assign occ_valid = occ_ce && !stall_now;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // ROM stall injection and address log, away from the active edge
  always @(negedge clk) begin
    if (occ_ce) addr_log.push_back(occ_addr);
    if (occ_ce && stall_cnt > 0) begin
      stall_now = 1'b1;
      stall_cnt = stall_cnt - 1;
    end else begin
      stall_now = 1'b0;
    end
  end

  // Output monitor
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got k=%0d l=%0d expected none", out_k, out_l);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_k", 32'(out_k), 32'(e.k));
        check("out_l", 32'(out_l), 32'(e.l));
        check("out_empty", 32'(out_empty), 32'(e.e));
        check("out_ovf", 32'(out_ovf), 32'(e.o));
      end
    end
  end

  task automatic issue(input logic [7:0] k, input logic [7:0] l, input logic [1:0] b,
                       input logic [7:0] ek, input logic [7:0] el,
                       input logic ee, input logic eo);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    addr_log.delete();
    e.k = ek; e.l = el; e.e = ee; e.o = eo;
    sb.push_back(e);
    in_k = k; in_l = l; in_base = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", 32'(out_valid), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    #22;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_occ_ce", 32'(occ_ce), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_k", 32'(out_k), 32'd0);
    @(negedge clk) rst = 1'b0;
    #1 check("idle_in_ready", 32'(in_ready), 32'd1);

    // basic
    mem[2] = 32'h00020100;
    mem[7] = 32'h01020302;
    issue(8'd3, 8'd7, BASE_C, 8'd6, 8'd7, 1'b0, 1'b0);
    check("basic_lat", 32'(lat), 32'd3);
    drain();
    check("basic_naddr", 32'(addr_log.size()), 32'd2);
    if (addr_log.size() == 2) begin
      check("basic_addr0", 32'(addr_log[0]), 32'd2);
      check("basic_addr1", 32'(addr_log[1]), 32'd7);
    end

    // k = 0
    mem[0] = 32'h00000001;
    issue(8'd0, 8'd0, BASE_A, 8'd2, 8'd2, 1'b0, 1'b0);
    drain();
    if (addr_log.size() > 0) check("k0_addr0", 32'(addr_log[0]), 32'hff);
    else check("k0_naddr", 32'(addr_log.size()), 32'd2);

    // empty
    mem[4] = 32'h00030000;
    mem[5] = 32'h00030000;
    issue(8'd5, 8'd5, BASE_G, 8'd12, 8'd11, 1'b1, 1'b0);
    drain();

    // overflow
    c_tbl = 32'hFA080401;
    mem[0] = 32'h0A000000;
    mem[1] = 32'h0A000000;
    issue(8'd1, 8'd1, BASE_T, 8'd5, 8'd4, 1'b1, 1'b1);
    drain();
    c_tbl = 32'h0C080401;

    // ROM stall in RD_K
    stall_cnt = 2;
    issue(8'd3, 8'd7, BASE_C, 8'd6, 8'd7, 1'b0, 1'b0);
    check("stall_lat", 32'(lat), 32'd5);
    drain();
    check("stall_naddr", 32'(addr_log.size()), 32'd4);
    if (addr_log.size() == 4) begin
      check("stall_hold", 32'(addr_log[2]), 32'd2);
      check("stall_addr_l", 32'(addr_log[3]), 32'd7);
    end

    // output backpressure with a competing request
    out_ready = 1'b0;
    issue(8'd3, 8'd7, BASE_C, 8'd6, 8'd7, 1'b0, 1'b0);
    check("bp_lat", 32'(lat), 32'd3);
    in_valid = 1'b1; in_k = 8'd9; in_l = 8'd9; in_base = BASE_T;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_k", 32'(out_k), 32'd6);
      check("bp_l", 32'(out_l), 32'd7);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 check("bp_release", 32'(out_valid), 32'd0);
    check("bp_idle", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 check("bp_no_accept", 32'(occ_ce), 32'd0);

    // reset during RD_L
    @(negedge clk);
    in_k = 8'd3; in_l = 8'd7; in_base = BASE_C; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 check("rdl_addr", 32'(occ_addr), 32'd7);
    rst = 1'b1;
    #1 check("rst_mid_ce", 32'(occ_ce), 32'd0);
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_ready", 32'(in_ready), 32'd0);
    @(negedge clk) rst = 1'b0;
    #1 check("rst_after_ready", 32'(in_ready), 32'd1);
    issue(8'd5, 8'd5, BASE_G, 8'd12, 8'd11, 1'b1, 1'b0);
    check("post_rst_lat", 32'(lat), 32'd3);
    drain();

    repeat (3) @(posedge clk);
    check("sb_left", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end expected finish");
    $fatal(1, "timeout");
  end

endmodule
